write_control: RTL and testbench
================================

# write_control

Write-side pointer and status controller for the synchronous FIFO. It pairs with the read-side controller. It accepts write requests from the producer, generates the memory write enable and the extended write address, and derives full, almost-full and fill level by comparing its own pointer with the read pointer. It also records overflow attempts for debug.

## Interface
Parameters:
- MEM_DEPTH, default `FIFO_DEPTH (16): FIFO depth in entries. Must be a power of two, at least 2.
- ADDR_WIDTH, default $clog2(MEM_DEPTH): memory address width.
- AF_THRESH, default MEM_DEPTH-2: almost-full asserts when level >= AF_THRESH. Legal range 1..MEM_DEPTH.
- OVF_CNT_WIDTH, default 8: width of the dropped-write counter.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- wr_valid, input, 1: producer requests a write this cycle.
- rd_addr, input, ADDR_WIDTH+1: read pointer from the read controller (registered, includes wrap bit).
- ovf_clr, input, 1: synchronous clear of wr_overflow and ovf_count.
- wr_en, output, 1: memory write strobe. Combinational: wr_valid & !wr_full.
- wr_addr, output, ADDR_WIDTH+1: registered write pointer. Memory index is wr_addr[ADDR_WIDTH-1:0].
- wr_full, output, 1: FIFO full. Combinational from wr_addr and rd_addr.
- wr_almost_full, output, 1: level >= AF_THRESH. Combinational.
- wr_level, output, ADDR_WIDTH+1: current occupancy, 0..MEM_DEPTH.
- wr_ack, output, 1: registered. High for one cycle after each accepted write.
- wr_overflow, output, 1: sticky flag. Set by any write attempted while full.
- ovf_count, output, OVF_CNT_WIDTH: saturating count of rejected writes.

## Operation
- **Pointer.** On each edge where wr_en=1, wr_addr <= wr_addr+1, modulo 2^(ADDR_WIDTH+1). The wrap bit toggles every MEM_DEPTH accepted writes.
- **Level.** wr_level = (wr_addr - rd_addr) mod 2^(ADDR_WIDTH+1), an unsigned ADDR_WIDTH+1-bit subtraction.
- **Full.** wr_full = (wr_addr[ADDR_WIDTH] != rd_addr[ADDR_WIDTH]) && (wr_addr[ADDR_WIDTH-1:0] == rd_addr[ADDR_WIDTH-1:0]). This is equivalent to wr_level == MEM_DEPTH.
- **Almost-full.** wr_almost_full = (wr_level >= AF_THRESH).
- **Rejected write.** A write attempted while full (wr_valid & wr_full) is dropped:
  - wr_en stays 0 and wr_addr is held.
  - wr_overflow <= 1.
  - ovf_count <= ovf_count+1, saturating at all-ones.
- **Clear.** When ovf_clr=1, wr_overflow <= 0 and ovf_count <= 0. If a rejected write occurs in the same cycle, the clear still takes priority.
- **Acknowledge.** wr_ack <= wr_en every cycle, so back-to-back accepted writes give a continuous wr_ack.
- **Empty.** The block does not compute empty; the read side owns that flag.
- **Bypass.** There is no bypass. When full, a simultaneous read and write rejects the write, because full is evaluated on pre-edge pointers.

## Timing
- **Reset values.** On reset_n=0, asynchronously: wr_addr=0, wr_ack=0, wr_overflow=0, ovf_count=0. With rd_addr=0 this gives wr_level=0, wr_full=0, wr_almost_full=0.
- **Write latency.** A write is accepted on the rising edge with wr_valid=1 and wr_full=0. The memory captures data at index wr_addr[ADDR_WIDTH-1:0] on that same edge. wr_addr, wr_level and wr_ack reflect the write from the next cycle.
- **Read visibility.** A read frees a slot one cycle after the read edge, once rd_addr updates. wr_full deasserts combinationally in that cycle, and a write can be accepted on the following edge.
- **Zero-cycle producer response.** wr_full and wr_en are combinational, so the producer samples wr_full in the same cycle it drives wr_valid. There is no skid buffer.
- **Wrap-around.** The pointer wraps from 2^(ADDR_WIDTH+1)-1 to 0 with no glitch in level or full.
- **Reset mid-operation.** All state clears immediately. The team guarantees that the read side is reset simultaneously.

## Test plan
- **Reset.** Assert reset_n=0 mid-burst -> wr_addr=0, wr_level=0, wr_ack=0, wr_overflow=0, ovf_count=0 immediately.
- **Fill.** MEM_DEPTH=16, rd_addr held at 0, 16 consecutive wr_valid cycles -> wr_addr reaches 16 (0x10) and wr_full=1. wr_almost_full rises after the 14th write, wr_level=16, and wr_ack is high for 16 cycles.
- **Overflow.** From full, 3 more wr_valid cycles -> wr_en=0, wr_addr stays 16, wr_overflow=1, ovf_count=3. A following ovf_clr pulse -> both return to 0.
- **Saturation.** OVF_CNT_WIDTH=2, 5 rejected writes -> ovf_count=3, not 1.
- **Full plus read.** While full, step rd_addr 0->1 -> wr_full=0 and wr_level=15 in the same cycle. The next wr_valid is accepted and wr_addr=17.
- **Wrap.** Stream 40 writes with rd_addr tracking wr_addr minus 2 -> wr_addr passes 31->0, wr_level stays 2, and wr_full is never asserted.

Source files
------------

// File: rtl/write_control.sv
// Write-side pointer/status controller for the synchronous FIFO: accepts producer writes, flags full/almost-full.
// Latency: wr_en/wr_full/wr_level combinational; wr_addr, wr_ack and overflow state update on the next edge.
// Backpressure: none buffered; a write seen while full is dropped and counted, the producer must honour wr_full.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif

module write_control #(
  parameter int MEM_DEPTH     = `FIFO_DEPTH,
  parameter int ADDR_WIDTH    = $clog2(MEM_DEPTH),
  parameter int AF_THRESH     = MEM_DEPTH - 2,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  input  logic [ADDR_WIDTH:0]      rd_addr,
  input  logic                     ovf_clr,
  output logic                     wr_en,
  output logic [ADDR_WIDTH:0]      wr_addr,
  output logic                     wr_full,
  output logic                     wr_almost_full,
  output logic [ADDR_WIDTH:0]      wr_level,
  output logic                     wr_ack,
  output logic                     wr_overflow,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  logic wr_reject;
  logic ovf_sat;

  // Pointers carry an extra wrap bit so full and empty stay distinguishable at equal indices.
  assign wr_full = (wr_addr[ADDR_WIDTH] != rd_addr[ADDR_WIDTH]) &&
                   (wr_addr[ADDR_WIDTH-1:0] == rd_addr[ADDR_WIDTH-1:0]);
  assign wr_level       = wr_addr - rd_addr;
  assign wr_almost_full = (wr_level >= AF_LVL);
  assign wr_en          = wr_valid & ~wr_full;
  assign wr_reject      = wr_valid & wr_full;
  assign ovf_sat        = &ovf_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr <= '0;
      wr_ack  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
      end
      wr_ack <= wr_en;
    end
  end

  // Clear wins over a same-cycle rejected write so software never sees a stale count after clearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_overflow <= 1'b0;
      ovf_count   <= '0;
    end else if (ovf_clr) begin
      wr_overflow <= 1'b0;
      ovf_count   <= '0;
    end else if (wr_reject) begin
      wr_overflow <= 1'b1;
      if (!ovf_sat) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_write_control.sv
// Self-checking bench for write_control: vector table, hand-written corner sequences and random traffic vs a model.
module tb_write_control;

  logic       clk;
  logic       reset_n;
  logic       wr_valid;
  logic [4:0] rd_addr;
  logic       ovf_clr;

  logic       wr_en, wr_full, wr_almost_full, wr_ack, wr_overflow;
  logic [4:0] wr_addr, wr_level;
  logic [7:0] ovf_count;

  logic       s_wr_en, s_wr_full, s_wr_almost_full, s_wr_ack, s_wr_overflow;
  logic [4:0] s_wr_addr, s_wr_level;
  logic [1:0] s_ovf_count;

  int n_cmp;
  int n_bad;

  write_control #(.MEM_DEPTH(16), .OVF_CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .rd_addr(rd_addr), .ovf_clr(ovf_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_full(wr_full), .wr_almost_full(wr_almost_full),
    .wr_level(wr_level), .wr_ack(wr_ack), .wr_overflow(wr_overflow), .ovf_count(ovf_count)
  );

  write_control #(.MEM_DEPTH(16), .OVF_CNT_WIDTH(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .rd_addr(rd_addr), .ovf_clr(ovf_clr),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_full(s_wr_full), .wr_almost_full(s_wr_almost_full),
    .wr_level(s_wr_level), .wr_ack(s_wr_ack), .wr_overflow(s_wr_overflow), .ovf_count(s_ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [4:0] rd;
    logic       clr;
    logic       en;
    logic [4:0] addr;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ack;
    logic       ovf;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    ovf_clr  = 1'b0;
    rd_addr  = 5'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcnt, rcnt, occ, mcnt, mcnt_s;
    bit movf, mack, en_e, full_e;

    n_cmp    = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    rd_addr  = 5'd0;
    ovf_clr  = 1'b0;

    // Fill, overflow, clear and full-plus-read, one row per cycle (expected values seen before the edge).
    for (int k = 0; k < 16; k++) begin
      tbl[k] = '{wv: 1'b1, rd: 5'd0, clr: 1'b0, en: 1'b1, addr: 5'(k), full: 1'b0,
                 af: (k >= 14), lvl: 5'(k), ack: (k > 0), ovf: 1'b0, cnt: 8'd0};
    end
    for (int k = 16; k < 19; k++) begin
      tbl[k] = '{wv: 1'b1, rd: 5'd0, clr: 1'b0, en: 1'b0, addr: 5'd16, full: 1'b1,
                 af: 1'b1, lvl: 5'd16, ack: (k == 16), ovf: (k > 16), cnt: 8'(k - 16)};
    end
    tbl[19] = '{wv: 1'b0, rd: 5'd0, clr: 1'b1, en: 1'b0, addr: 5'd16, full: 1'b1,
                af: 1'b1, lvl: 5'd16, ack: 1'b0, ovf: 1'b1, cnt: 8'd3};
    tbl[20] = '{wv: 1'b0, rd: 5'd0, clr: 1'b0, en: 1'b0, addr: 5'd16, full: 1'b1,
                af: 1'b1, lvl: 5'd16, ack: 1'b0, ovf: 1'b0, cnt: 8'd0};
    tbl[21] = '{wv: 1'b1, rd: 5'd1, clr: 1'b0, en: 1'b1, addr: 5'd16, full: 1'b0,
                af: 1'b1, lvl: 5'd15, ack: 1'b0, ovf: 1'b0, cnt: 8'd0};
    tbl[22] = '{wv: 1'b0, rd: 5'd1, clr: 1'b0, en: 1'b0, addr: 5'd17, full: 1'b1,
                af: 1'b1, lvl: 5'd16, ack: 1'b1, ovf: 1'b0, cnt: 8'd0};

    // Reset state.
    #1;
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_level", 32'(wr_level), 32'd0);
    check("rst_full", 32'(wr_full), 32'd0);
    check("rst_af", 32'(wr_almost_full), 32'd0);
    check("rst_ack", 32'(wr_ack), 32'd0);
    check("rst_ovf", 32'(wr_overflow), 32'd0);
    check("rst_cnt", 32'(ovf_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      wr_valid = tbl[i].wv;
      rd_addr  = tbl[i].rd;
      ovf_clr  = tbl[i].clr;
      #1;
      check($sformatf("tbl%0d_en", i), 32'(wr_en), 32'(tbl[i].en));
      check($sformatf("tbl%0d_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
      check($sformatf("tbl%0d_full", i), 32'(wr_full), 32'(tbl[i].full));
      check($sformatf("tbl%0d_af", i), 32'(wr_almost_full), 32'(tbl[i].af));
      check($sformatf("tbl%0d_lvl", i), 32'(wr_level), 32'(tbl[i].lvl));
      check($sformatf("tbl%0d_ack", i), 32'(wr_ack), 32'(tbl[i].ack));
      check($sformatf("tbl%0d_ovf", i), 32'(wr_overflow), 32'(tbl[i].ovf));
      check($sformatf("tbl%0d_cnt", i), 32'(ovf_count), 32'(tbl[i].cnt));
    end

    // Saturation: five rejected writes, 8-bit counter reads 5, 2-bit counter sticks at 3.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      ovf_clr  = 1'b0;
      #1;
      check("sat_en", 32'(wr_en), 32'd0);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("sat_cnt8", 32'(ovf_count), 32'd5);
    check("sat_cnt2", 32'(s_ovf_count), 32'd3);
    check("sat_ovf", 32'(s_wr_overflow), 32'd1);
    check("sat_addr", 32'(wr_addr), 32'd17);

    // Clear coinciding with a rejected write: clear wins.
    @(negedge clk);
    wr_valid = 1'b1;
    ovf_clr  = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    ovf_clr  = 1'b0;
    #1;
    check("clrpri_cnt", 32'(ovf_count), 32'd0);
    check("clrpri_ovf", 32'(wr_overflow), 32'd0);

    // Reset asserted mid-burst clears state immediately.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
    end
    #1;
    check("burst_addr", 32'(wr_addr), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_addr", 32'(wr_addr), 32'd0);
    check("midrst_level", 32'(wr_level), 32'd0);
    check("midrst_ack", 32'(wr_ack), 32'd0);
    check("midrst_ovf", 32'(wr_overflow), 32'd0);
    check("midrst_cnt", 32'(ovf_count), 32'd0);
    wr_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Wrap: 40 writes with the read pointer trailing by two.
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      rd_addr  = 5'(((w >= 2) ? w - 2 : 0) % 32);
      wr_valid = 1'b1;
      #1;
      check("wrap_addr", 32'(wr_addr), 32'(w % 32));
      check("wrap_level", 32'((w >= 2) ? 2 : w), 32'(wr_level));
      check("wrap_full", 32'(wr_full), 32'd0);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("wrap_final_addr", 32'(wr_addr), 32'd8);

    // Random traffic against an occupancy model built from write/read totals.
    do_reset();
    wcnt   = 0;
    rcnt   = 0;
    mcnt   = 0;
    mcnt_s = 0;
    movf   = 1'b0;
    mack   = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rcnt < wcnt && $urandom_range(1, 0) == 1) rcnt++;
      rd_addr  = 5'(rcnt % 32);
      wr_valid = ($urandom_range(3, 0) != 0);
      ovf_clr  = ($urandom_range(15, 0) == 0);
      #1;
      occ    = wcnt - rcnt;
      full_e = (occ == 16);
      en_e   = wr_valid && !full_e;
      check("rnd_en", 32'(wr_en), 32'(en_e));
      check("rnd_full", 32'(wr_full), 32'(full_e));
      check("rnd_level", 32'(wr_level), 32'(occ));
      check("rnd_af", 32'(wr_almost_full), 32'(occ >= 14));
      check("rnd_addr", 32'(wr_addr), 32'(wcnt % 32));
      check("rnd_ack", 32'(wr_ack), 32'(mack));
      check("rnd_ovf", 32'(wr_overflow), 32'(movf));
      check("rnd_cnt", 32'(ovf_count), 32'(mcnt));
      check("rnd_cnt2", 32'(s_ovf_count), 32'(mcnt_s));
      if (ovf_clr) begin
        movf   = 1'b0;
        mcnt   = 0;
        mcnt_s = 0;
      end else if (wr_valid && full_e) begin
        movf = 1'b1;
        if (mcnt < 255) mcnt++;
        if (mcnt_s < 3) mcnt_s++;
      end
      mack = en_e;
      if (en_e) wcnt++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
